// File: rtl/control_sequencer.sv
// Instruction-sequencing FSM: fetches via the IR handshake, decodes the opcode,
// and issues single-cycle datapath strobes until END or an illegal opcode.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic             z_flag,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ar_inc,
  output logic             ac_load,
  output logic [1:0]       alu_op,
  output logic [1:0]       bus_sel,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LDAC  = 8'h01;
  localparam logic [7:0] OP_STAC  = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_INCAR = 8'h05;
  localparam logic [7:0] OP_JMPZ  = 8'h06;
  localparam logic [7:0] OP_JUMP  = 8'h07;
  localparam logic [7:0] OP_END   = 8'hFF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] BUS_MEM  = 2'b00;
  localparam logic [1:0] BUS_AC   = 2'b01;
  localparam logic [1:0] BUS_ALU  = 2'b10;

  state_t           state_reg, state_next;
  logic             store_reg, store_next;
  logic             illegal_reg, illegal_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      store_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      store_reg   <= store_next;
      illegal_reg <= illegal_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    store_next   = store_reg;
    illegal_next = illegal_reg;
    count_next   = count_reg;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    addr_sel     = 1'b0;
    ir_write     = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ar_inc       = 1'b0;
    ac_load      = 1'b0;
    alu_op       = ALU_PASS;
    bus_sel      = BUS_MEM;

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_inc     = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Legal opcodes retire here; the default branch overrides for illegal ones.
        count_next = count_reg + CNT_W'(1);
        state_next = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_LDAC, OP_STAC: begin
            store_next = (opcode == OP_STAC);
            state_next = S_MEM;
          end
          OP_ADD: begin
            alu_op  = ALU_ADD;
            bus_sel = BUS_ALU;
            ac_load = 1'b1;
          end
          OP_SUB: begin
            alu_op  = ALU_SUB;
            bus_sel = BUS_ALU;
            ac_load = 1'b1;
          end
          OP_INCAR: ar_inc = 1'b1;
          OP_JMPZ:  pc_load = z_flag;
          OP_JUMP:  pc_load = 1'b1;
          OP_END:   state_next = S_HALT;
          default: begin
            count_next   = count_reg;
            illegal_next = 1'b1;
            state_next   = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        // Direction comes from the opcode latched at DECODE, not the live IR.
        addr_sel = 1'b1;
        if (store_reg) begin
          mem_write = 1'b1;
          bus_sel   = BUS_AC;
        end else begin
          mem_read = 1'b1;
          bus_sel  = BUS_MEM;
          ac_load  = mem_ready;
        end
        if (mem_ready) state_next = S_FETCH;
      end

      S_HALT: ;

      default: state_next = S_IDLE;
    endcase
  end

  assign busy        = (state_reg == S_FETCH) || (state_reg == S_DECODE) || (state_reg == S_MEM);
  assign halted      = (state_reg == S_HALT);
  assign illegal     = illegal_reg;
  assign instr_count = count_reg;

endmodule
